// File: rtl/raytrace_pkg.sv
// Shared fixed-point types, constants and FSM states for the ray/plane intersection path.
package raytrace_pkg;

  localparam int Q_BITS  = 10;
  localparam int D_WIDTH = 32;
  localparam int ACC_W   = 2*D_WIDTH + 3;

  typedef logic signed [D_WIDTH-1:0] fx_t;
  typedef fx_t [2:0] vec3_t;

  localparam fx_t FP_ONE  = fx_t'(1 << Q_BITS);
  localparam fx_t SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam fx_t SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  typedef struct packed {
    vec3_t o;
    vec3_t d;
    vec3_t p;
    vec3_t n;
  } ray_rec_t;

  // Clamp a wide accumulator into the signed D_WIDTH range.
  function automatic fx_t sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-D_WIDTH){1'b0}}, SAT_MAX};
    lo = {{(ACC_W-D_WIDTH){1'b1}}, SAT_MIN};
    if (v > hi)      return SAT_MAX;
    else if (v < lo) return SAT_MIN;
    else             return v[D_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fixed_mul.sv
// Signed fixed-point multiply, result rescaled by >>> Q_BITS (floor toward -inf); purely combinational.
module fixed_mul
  import raytrace_pkg::*;
#(
  parameter int A_W = D_WIDTH,
  parameter int B_W = D_WIDTH
) (
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] p
);

  logic signed [A_W+B_W-1:0] full;

  assign full = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
  assign p    = full >>> Q_BITS;

endmodule

// File: rtl/ray_plane_setup.sv
// Pops {O,D,P,N}, forms num=N.(P-O) and den=N.D over 3 MAC cycles, pushes saturated pair to the divider FIFO.
// Push no earlier than 4 cycles after pop; holds outputs while out_full. DENOM_GUARD_EN adds the parallel-ray guard.
module ray_plane_setup
  import raytrace_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3*D_WIDTH-1:0] origin,
  input  logic [3*D_WIDTH-1:0] direction,
  input  logic [3*D_WIDTH-1:0] plane_pt,
  input  logic [3*D_WIDTH-1:0] normal,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic [D_WIDTH-1:0]   dividend,
  output logic [D_WIDTH-1:0]   divisor,
  input  logic                 out_full,
  output logic                 out_wr_en
`ifdef DENOM_GUARD_EN
  ,
  output logic                 degenerate
`endif
);

  state_t                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  ray_rec_t                rec_q, rec_d;
  logic signed [ACC_W-1:0] acc_n_q, acc_n_d;
  logic signed [ACC_W-1:0] acc_d_q, acc_d_d;
  fx_t                     dividend_q, dividend_d;
  fx_t                     divisor_q, divisor_d;
  logic                    degenerate_q, degenerate_d;

  fx_t                         o_k, d_k, p_k, n_k;
  logic signed [D_WIDTH:0]     e_k;
  logic signed [2*D_WIDTH:0]   prod_n;
  logic signed [2*D_WIDTH-1:0] prod_d;
  logic signed [ACC_W-1:0]     sum_n, sum_d;
  fx_t                         num_sat, den_sat;

  assign o_k = rec_q.o[k_q];
  assign d_k = rec_q.d[k_q];
  assign p_k = rec_q.p[k_q];
  assign n_k = rec_q.n[k_q];
  // One extra bit so P-O never wraps.
  assign e_k = {p_k[D_WIDTH-1], p_k} - {o_k[D_WIDTH-1], o_k};

  fixed_mul #(.A_W(D_WIDTH), .B_W(D_WIDTH+1)) u_mul_num (.a(n_k), .b(e_k), .p(prod_n));
  fixed_mul #(.A_W(D_WIDTH), .B_W(D_WIDTH))   u_mul_den (.a(n_k), .b(d_k), .p(prod_d));

  assign sum_n   = acc_n_q + {{(ACC_W-2*D_WIDTH-1){prod_n[2*D_WIDTH]}}, prod_n};
  assign sum_d   = acc_d_q + {{(ACC_W-2*D_WIDTH){prod_d[2*D_WIDTH-1]}}, prod_d};
  assign num_sat = sat(sum_n);
  assign den_sat = sat(sum_d);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    rec_d        = rec_q;
    acc_n_d      = acc_n_q;
    acc_d_d      = acc_d_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    degenerate_d = degenerate_q;
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          rec_d.o  = origin;
          rec_d.d  = direction;
          rec_d.p  = plane_pt;
          rec_d.n  = normal;
          k_d      = 2'd0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_n_d = sum_n;
        acc_d_d = sum_d;
        if (k_q == 2'd2) begin
          dividend_d   = num_sat;
          divisor_d    = den_sat;
          degenerate_d = 1'b0;
`ifdef DENOM_GUARD_EN
          // |den| <= 1 LSB: ray parallel to plane, steer divider to t=-1.0 (miss).
          if (den_sat == fx_t'(0) || den_sat == fx_t'(1) || den_sat == fx_t'(-1)) begin
            dividend_d   = -FP_ONE;
            divisor_d    = FP_ONE;
            degenerate_d = 1'b1;
          end
`endif
          state_d = WRITE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          acc_n_d   = '0;
          acc_d_d   = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // No FIFO side effects while reset is held.
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      rec_q        <= '0;
      acc_n_q      <= '0;
      acc_d_q      <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      degenerate_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rec_q        <= rec_d;
      acc_n_q      <= acc_n_d;
      acc_d_q      <= acc_d_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      degenerate_q <= degenerate_d;
    end
  end

  assign dividend = dividend_q;
  assign divisor  = divisor_q;
`ifdef DENOM_GUARD_EN
  assign degenerate = degenerate_q;
`endif

endmodule
